// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int CNT_W = 4;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : DEPTH x DATA_W storage, synchronous write, registered read.
//               Out-of-range reads return zero; out-of-range writes drop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = (32'(addr) < DEPTH);
  assign w_idx      = addr[IDX_W-1:0];

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      r_mem[w_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency load/store responder with pipeline stall and
//               one-cycle read-valid strobe. Optional access/stall counters
//               are built when DMEM_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_cnt,
  output logic [STAT_W-1:0] wr_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] C_LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  op_t               r_op;
  logic              r_both;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req;
  logic              w_stall;
  logic              w_acc;
  op_t               w_op;
  logic              w_both;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_oor;
  logic              w_re;
  logic              w_we;

  assign w_req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // With LATENCY==1 the access fires straight from IDLE using the live inputs.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_stall     = 1'b0;
    w_acc       = 1'b0;
    w_op        = r_op;
    w_both      = r_both;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_stall    = 1'b1;
          w_cnt_next = C_LAT_M1;
          if (LATENCY == 1) begin
            w_next      = DONE;
            w_acc       = 1'b1;
            w_op        = mem_read ? OP_RD : OP_WR;
            w_both      = mem_read & mem_write;
            w_acc_addr  = addr;
            w_acc_wdata = wdata;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall    = 1'b1;
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == C_ONE) begin
          w_next = DONE;
          w_acc  = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_RD;
      r_both  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_op    <= mem_read ? OP_RD : OP_WR;
      r_both  <= mem_read & mem_write;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  assign w_oor = (32'(w_acc_addr) >= DEPTH);
  assign w_re  = w_acc && (w_op == OP_RD) && !rst;
  assign w_we  = w_acc && (w_op == OP_WR) && !rst;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_acc_addr),
    .wdata (w_acc_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (w_acc && (w_both || w_oor)) begin
      err <= 1'b1;
    end
  end

  assign stall       = w_stall;
  assign rdata_valid = (r_state == DONE) && (r_op == OP_RD);

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] r_rd_cnt;
  logic [STAT_W-1:0] r_wr_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_re)    r_rd_cnt    <= sat_inc(r_rd_cnt);
      if (w_we)    r_wr_cnt    <= sat_inc(r_wr_cnt);
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign rd_cnt    = r_rd_cnt;
  assign wr_cnt    = r_wr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
